// File: rtl/alu_ctrl_sequencer.sv
// Multi-phase ALU control sequencer: IDLE -> [ADDR] -> EXEC -> [INCDEC] -> DONE.
// Optional freeze input enabled by defining ALU_SEQ_STALL_EN.
module alu_ctrl_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       OP_ADDR,
  input  logic       OP_MOV,
  input  logic       OP_INCDEC,
  input  logic       OP_DEC,
  input  logic [3:0] CTRL_IN,
`ifdef ALU_SEQ_STALL_EN
  input  logic       STALL,
`endif
  output logic       BUSY,
  output logic       ACK,
  output logic       ADDRESS_MODE,
  output logic       INTERNAL_MOV,
  output logic       INTERNAL_INC_DEC,
  output logic       INTERNAL_DEC,
  output logic [3:0] CTRL_OUT,
  output logic [2:0] PHASE
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    EXEC   = 3'd2,
    INCDEC = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       addr_q, addr_d;
  logic       mov_q, mov_d;
  logic       incdec_q, incdec_d;
  logic       dec_q, dec_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic       stall;

`ifdef ALU_SEQ_STALL_EN
  assign stall = STALL;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= 1'b0;
      mov_q    <= 1'b0;
      incdec_q <= 1'b0;
      dec_q    <= 1'b0;
      ctrl_q   <= 4'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mov_q    <= mov_d;
      incdec_q <= incdec_d;
      dec_q    <= dec_d;
      ctrl_q   <= ctrl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mov_d    = mov_q;
    incdec_d = incdec_q;
    dec_d    = dec_q;
    ctrl_d   = ctrl_q;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          addr_d   = OP_ADDR;
          mov_d    = OP_MOV;
          incdec_d = OP_INCDEC;
          dec_d    = OP_DEC;
          ctrl_d   = CTRL_IN;
          state_d  = OP_ADDR ? ADDR : EXEC;
        end
      end
      ADDR:    if (!stall) state_d = EXEC;
      EXEC:    if (!stall) state_d = incdec_q ? INCDEC : DONE;
      INCDEC:  if (!stall) state_d = DONE;
      DONE:    if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state and latched fields.
  always_comb begin
    BUSY             = 1'b0;
    ACK              = 1'b0;
    ADDRESS_MODE     = 1'b0;
    INTERNAL_MOV     = 1'b0;
    INTERNAL_INC_DEC = 1'b0;
    INTERNAL_DEC     = 1'b0;
    CTRL_OUT         = 4'h0;
    PHASE            = state_q;
    case (state_q)
      ADDR: begin
        BUSY         = 1'b1;
        ADDRESS_MODE = addr_q;
        CTRL_OUT     = ctrl_q;
      end
      EXEC: begin
        BUSY         = 1'b1;
        INTERNAL_MOV = mov_q;
        CTRL_OUT     = ctrl_q;
      end
      INCDEC: begin
        BUSY             = 1'b1;
        INTERNAL_INC_DEC = 1'b1;
        INTERNAL_DEC     = dec_q;
        CTRL_OUT         = ctrl_q;
      end
      DONE: begin
        BUSY = 1'b1;
        ACK  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed scoreboard bench for alu_ctrl_sequencer; stall scenario built when
// ALU_SEQ_STALL_EN is defined.
module tb_alu_ctrl_sequencer;

  logic       CLK = 1'b0;
  logic       RST, REQ, OP_ADDR, OP_MOV, OP_INCDEC, OP_DEC, STALL;
  logic [3:0] CTRL_IN;
  logic       BUSY, ACK, ADDRESS_MODE, INTERNAL_MOV, INTERNAL_INC_DEC, INTERNAL_DEC;
  logic [3:0] CTRL_OUT;
  logic [2:0] PHASE;

  int checks = 0;
  int errors = 0;
  logic [12:0] sb[$];
  logic [12:0] exp_v, act_v;

  always #5 CLK = ~CLK;

  alu_ctrl_sequencer dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP_ADDR(OP_ADDR), .OP_MOV(OP_MOV),
    .OP_INCDEC(OP_INCDEC), .OP_DEC(OP_DEC), .CTRL_IN(CTRL_IN),
`ifdef ALU_SEQ_STALL_EN
    .STALL(STALL),
`endif
    .BUSY(BUSY), .ACK(ACK), .ADDRESS_MODE(ADDRESS_MODE), .INTERNAL_MOV(INTERNAL_MOV),
    .INTERNAL_INC_DEC(INTERNAL_INC_DEC), .INTERNAL_DEC(INTERNAL_DEC),
    .CTRL_OUT(CTRL_OUT), .PHASE(PHASE)
  );

  // Flag order: busy, ack, address_mode, internal_mov, internal_inc_dec, internal_dec
  function automatic logic [12:0] ev(input logic [2:0] ph, input logic [5:0] fl,
                                     input logic [3:0] ct);
    return {ph, fl, ct};
  endfunction

  function automatic logic [12:0] observed();
    return {PHASE, BUSY, ACK, ADDRESS_MODE, INTERNAL_MOV, INTERNAL_INC_DEC,
            INTERNAL_DEC, CTRL_OUT};
  endfunction

  task automatic set_op(input logic req, input logic a, input logic m,
                        input logic i, input logic d, input logic [3:0] c);
    REQ = req; OP_ADDR = a; OP_MOV = m; OP_INCDEC = i; OP_DEC = d; CTRL_IN = c;
  endtask

  task automatic test_reset();
    RST = 1'b1; STALL = 1'b1;
    set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hC);
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      exp_v = sb.pop_front(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL reset c%0d: got %h want %h", c, act_v, exp_v);
      end
    end
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    STALL = 1'b0; RST = 1'b0;
  endtask

  task automatic test_mov();
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA);
    sb.push_back(ev(3'd2, 6'b100100, 4'hA));
    sb.push_back(ev(3'd4, 6'b110000, 4'h0));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      exp_v = sb.pop_front(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL mov c%0d: got %h want %h", c, act_v, exp_v);
      end
      if (c == 0) REQ = 1'b0;
    end
  endtask

  task automatic test_full_path();
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5);
    sb.push_back(ev(3'd1, 6'b101000, 4'h5));
    sb.push_back(ev(3'd2, 6'b100000, 4'h5));
    sb.push_back(ev(3'd3, 6'b100011, 4'h5));
    sb.push_back(ev(3'd4, 6'b110000, 4'h0));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      exp_v = sb.pop_front(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL full_path c%0d: got %h want %h", c, act_v, exp_v);
      end
      if (c == 0) REQ = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
    sb.push_back(ev(3'd2, 6'b100000, 4'h3));
    sb.push_back(ev(3'd4, 6'b110000, 4'h0));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    sb.push_back(ev(3'd1, 6'b101000, 4'hF));
    sb.push_back(ev(3'd2, 6'b100100, 4'hF));
    sb.push_back(ev(3'd4, 6'b110000, 4'h0));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    for (int c = 0; c < 7; c++) begin
      @(posedge CLK); #1;
      exp_v = sb.pop_front(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL back_to_back c%0d: got %h want %h", c, act_v, exp_v);
      end
      if (c == 0) begin
        CTRL_IN = 4'hF; OP_MOV = 1'b1; OP_ADDR = 1'b1;
      end
      if (c == 3) REQ = 1'b0;
    end
  endtask

  task automatic test_reset_mid_op();
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7);
    sb.push_back(ev(3'd2, 6'b100000, 4'h7));
    sb.push_back(ev(3'd3, 6'b100010, 4'h7));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      exp_v = sb.pop_front(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL reset_mid_op c%0d: got %h want %h", c, act_v, exp_v);
      end
      if (c == 0) REQ = 1'b0;
      if (c == 1) RST = 1'b1;
      if (c == 2) RST = 1'b0;
    end
  endtask

  task automatic test_dec_no_incdec();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
    sb.push_back(ev(3'd2, 6'b100000, 4'h9));
    sb.push_back(ev(3'd4, 6'b110000, 4'h0));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      exp_v = sb.pop_front(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL dec_no_incdec c%0d: got %h want %h", c, act_v, exp_v);
      end
      if (c == 0) REQ = 1'b0;
    end
  endtask

`ifdef ALU_SEQ_STALL_EN
  task automatic test_stall();
    STALL = 1'b1;
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6);
    sb.push_back(ev(3'd2, 6'b100100, 4'h6));
    for (int k = 0; k < 3; k++) sb.push_back(ev(3'd2, 6'b100100, 4'h6));
    sb.push_back(ev(3'd4, 6'b110000, 4'h0));
    sb.push_back(ev(3'd4, 6'b110000, 4'h0));
    sb.push_back(ev(3'd0, 6'b000000, 4'h0));
    for (int c = 0; c < 7; c++) begin
      @(posedge CLK); #1;
      exp_v = sb.pop_front(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL stall c%0d: got %h want %h", c, act_v, exp_v);
      end
      if (c == 0) REQ = 1'b0;
      if (c == 3) STALL = 1'b0;
      if (c == 4) STALL = 1'b1;
      if (c == 5) STALL = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mov();
    test_full_path();
    test_back_to_back();
    test_reset_mid_op();
    test_dec_no_incdec();
`ifdef ALU_SEQ_STALL_EN
    test_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_sequencer.md
ALU_CTRL_SEQUENCER -- requirements
Module: alu_ctrl_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active-high.
REQ-002 The block SHALL have these ports:
- REQ  in  1  start request; sampled only in IDLE.
- OP_ADDR  in  1  operation needs an address-mode phase.
- OP_MOV  in  1  operation is an internal move.
- OP_INCDEC  in  1  operation needs a post inc/dec phase.
- OP_DEC  in  1  inc/dec direction (1 = decrement).
- CTRL_IN  in  4  base ALU control field for the operation.
- STALL  in  1  freeze request; present only with ALU_SEQ_STALL_EN.
- BUSY  out  1  high in any state other than IDLE.
- ACK  out  1  one-cycle completion pulse.
- ADDRESS_MODE  out  1  address-mode phase strobe to the ALU control decoders.
- INTERNAL_MOV  out  1  move strobe to the ALU control decoders.
- INTERNAL_INC_DEC  out  1  inc/dec phase strobe.
- INTERNAL_DEC  out  1  decrement select during the inc/dec phase.
- CTRL_OUT  out  4  latched ALU control field.
- PHASE  out  3  current state encoding.

Function
REQ-003 The block SHALL implement these states, encoded as IDLE=0, ADDR=1, EXEC=2, INCDEC=3, DONE=4 and reflected on PHASE.
REQ-004 In IDLE with REQ=1, the block SHALL latch OP_ADDR, OP_MOV, OP_INCDEC, OP_DEC and CTRL_IN, then go to ADDR if OP_ADDR=1, else to EXEC.
REQ-005 Transitions SHALL be:
- ADDR -> EXEC unconditionally.
- EXEC -> INCDEC if latched OP_INCDEC=1, else EXEC -> DONE.
- INCDEC -> DONE.
- DONE -> IDLE.
REQ-006 The block SHALL ignore REQ and all OP_* and CTRL_IN inputs in every state other than IDLE; latched values SHALL hold until the next acceptance.
REQ-007 Every output SHALL be decoded only from registered state and latched fields, with no combinational path from any input to any output.
REQ-008 Output decode SHALL be:
- ADDRESS_MODE = 1 only in ADDR.
- INTERNAL_MOV = 1 only in EXEC with latched OP_MOV=1.
- INTERNAL_INC_DEC = 1 only in INCDEC.
- INTERNAL_DEC = 1 only in INCDEC with latched OP_DEC=1.
- ACK = 1 only in DONE.
REQ-009 CTRL_OUT SHALL equal the latched CTRL_IN in ADDR, EXEC and INCDEC, and SHALL be 4'h0 in IDLE and DONE.
REQ-010 Latency from the edge that samples REQ to ACK high SHALL be 2 + OP_ADDR + OP_INCDEC cycles; minimum 2, maximum 4.
REQ-011 A latched OP_DEC with OP_INCDEC=0 SHALL have no effect on any output.
REQ-012 REQ held high continuously SHALL be accepted again on the first IDLE cycle after DONE, giving at least one IDLE cycle between operations.

Reset
REQ-013 While RST=1 at a rising edge, the block SHALL enter IDLE and clear all latched fields to 0, regardless of current state, including mid-operation.
REQ-014 After reset, all outputs SHALL be 0: BUSY, ACK, ADDRESS_MODE, INTERNAL_MOV, INTERNAL_INC_DEC, INTERNAL_DEC, CTRL_OUT=4'h0, PHASE=3'd0.
REQ-015 RST SHALL take priority over REQ and STALL, and no ACK SHALL be issued for an operation aborted by reset.

Configuration
REQ-016 Macro ALU_SEQ_STALL_EN, when defined:
- The STALL port SHALL exist.
- With STALL=1 in any state other than IDLE, state and latched fields SHALL hold, and outputs SHALL stay at their current values.
- A stall in DONE SHALL extend ACK for the stall duration.
- STALL SHALL have no effect in IDLE.
REQ-017 Without ALU_SEQ_STALL_EN, the STALL port SHALL be absent and the sequencer SHALL never freeze.

Verification
REQ-018 A bench SHALL cover these directed scenarios:
- Reset, then REQ=1, OP_ADDR=0, OP_MOV=1, OP_INCDEC=0, CTRL_IN=4'hA -> next cycle EXEC with INTERNAL_MOV=1 and CTRL_OUT=4'hA; following cycle ACK=1; then IDLE with CTRL_OUT=4'h0.
- REQ with OP_ADDR=1, OP_INCDEC=1, OP_DEC=1, CTRL_IN=4'h5 -> PHASE 1,2,3,4,0 on consecutive cycles; ADDRESS_MODE in cycle 1; INTERNAL_INC_DEC=INTERNAL_DEC=1 in cycle 3; ACK in cycle 4.
- REQ held high with CTRL_IN changed to 4'hF mid-operation -> CTRL_OUT stays at the first value; second acceptance only after one IDLE cycle.
- RST=1 asserted in INCDEC -> next cycle PHASE=0, all outputs 0, no ACK.
- OP_DEC=1 with OP_INCDEC=0 -> INTERNAL_DEC never asserted, ACK 2 cycles after acceptance.
- With ALU_SEQ_STALL_EN defined, STALL=1 for 3 cycles in EXEC -> PHASE stays 2 and INTERNAL_MOV stays high for 3 extra cycles; ACK is delayed by 3 cycles.
